// File: rtl/rv32_alu_sliced_fsm_pkg.sv
// Shared types for the sliced RV32I ALU: operation codes and controller states.
package rv32_alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/rv32_alu_sliced_fsm_slice.sv
// Combinational SLICE_W-bit ALU slice; chained across cycles through an external carry register.
module rv32_alu_slice
  import rv32_alu_pkg::*;
#(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  input  alu_op_t            op,
  output logic [SLICE_W-1:0] y,
  output logic               c_out
);

  logic [SLICE_W:0] sum;

  always_comb begin
    sum   = '0;
    y     = '0;
    c_out = 1'b0;
    case (op)
      ALU_ADD: begin
        sum   = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, c_in};
        y     = sum[SLICE_W-1:0];
        c_out = sum[SLICE_W];
      end
      // Subtract as a + ~b with the initial carry preloaded to 1.
      ALU_SUB: begin
        sum   = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, c_in};
        y     = sum[SLICE_W-1:0];
        c_out = sum[SLICE_W];
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rv32_alu_sliced_fsm.sv
// Multicycle bit-sliced RV32I ALU: one SLICE_W slice per cycle through one shared slice datapath.
// state  | meaning
// S_IDLE | ready; captures op and operands on i_valid
// S_EXEC | one slice per cycle, LSB slice first, carry rippled in carry_q
// S_DONE | result held until the consumer asserts i_ready
module rv32_alu_sliced_fsm
  import rv32_alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_operand_one,
  input  logic [DATA_W-1:0] i_operand_two,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry_out,
  output logic              o_zero,
  output logic              o_busy
);

  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

  if (DATA_W % SLICE_W != 0) begin : g_bad_width
    $error("rv32_alu_sliced_fsm: DATA_W must be a multiple of SLICE_W");
  end

  alu_state_t        state_q, state_d;
  alu_op_t           op_q;
  logic [DATA_W-1:0] a_q, b_q, result_q;
  logic [CNT_W-1:0]  slice_cnt;
  logic              carry_q;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_y;
  logic               slice_c;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b1;
    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        if (i_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (slice_cnt == LAST_SLICE) state_d = S_DONE;
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign slice_a = a_q[int'(slice_cnt) * SLICE_W +: SLICE_W];
  assign slice_b = b_q[int'(slice_cnt) * SLICE_W +: SLICE_W];

  rv32_alu_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .op    (op_q),
    .y     (slice_y),
    .c_out (slice_c)
  );

  // Registers only move in IDLE (capture) and EXEC, so DONE holds everything under backpressure.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q      <= ALU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      slice_cnt <= '0;
      carry_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            op_q      <= alu_op_t'(i_op);
            a_q       <= i_operand_one;
            b_q       <= i_operand_two;
            slice_cnt <= '0;
            carry_q   <= (i_op == ALU_SUB);
          end
        end
        S_EXEC: begin
          result_q[int'(slice_cnt) * SLICE_W +: SLICE_W] <= slice_y;
          carry_q <= slice_c;
          if (slice_cnt != LAST_SLICE) slice_cnt <= slice_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_result    = result_q;
  assign o_carry_out = carry_q;
  assign o_zero      = (result_q == '0);

endmodule

// File: tb/tb_rv32_alu_sliced_fsm.sv
// Self-checking bench: three ALU instances (SLICE_W 16, 8, 32) against an arithmetic reference model.
module tb_rv32_alu_sliced_fsm;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        vld     [NDUT];
  logic [2:0]  opv     [NDUT];
  logic [31:0] av      [NDUT];
  logic [31:0] bv      [NDUT];
  logic        rdy_in  [NDUT];
  logic        rdy_out [NDUT];
  logic        val_out [NDUT];
  logic [31:0] res     [NDUT];
  logic        cout    [NDUT];
  logic        zero    [NDUT];
  logic        busy    [NDUT];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int SW = (g == 0) ? 16 : ((g == 1) ? 8 : 32);
    rv32_alu_sliced_fsm #(.DATA_W(32), .SLICE_W(SW)) u_dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_valid       (vld[g]),
      .o_ready       (rdy_out[g]),
      .i_op          (opv[g]),
      .i_operand_one (av[g]),
      .i_operand_two (bv[g]),
      .o_valid       (val_out[g]),
      .i_ready       (rdy_in[g]),
      .o_result      (res[g]),
      .o_carry_out   (cout[g]),
      .o_zero        (zero[g]),
      .o_busy        (busy[g])
    );
  end

  function automatic int num_slices(input int idx);
    case (idx)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  // Returns {carry, result} computed on whole 32-bit words.
  function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} + {1'b0, ~b} + 33'd1;
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      default: return 33'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input int idx, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall, input string tag);
    logic [32:0] exp;
    int          lat;
    bit          got;
    exp = ref_alu(op, a, b);
    @(negedge clk);
    check({tag, " ready_idle"}, rdy_out[idx], 1);
    vld[idx] = 1'b1;
    opv[idx] = op;
    av[idx]  = a;
    bv[idx]  = b;
    got = 0;
    lat = 0;
    @(posedge clk);
    lat = 1;
    for (int c = 0; c < 40; c++) begin
      // Requester keeps i_valid high with changing payload; the busy block must ignore it.
      #1;
      opv[idx] = 3'($urandom_range(0, 7));
      av[idx]  = $urandom;
      bv[idx]  = $urandom;
      @(negedge clk);
      if (val_out[idx]) begin
        got = 1;
        break;
      end
      check({tag, " ready_busy"}, rdy_out[idx], 0);
      check({tag, " busy"}, busy[idx], 1);
      @(posedge clk);
      lat++;
    end
    vld[idx] = 1'b0;
    check({tag, " valid_seen"}, got, 1);
    check({tag, " latency"}, lat, num_slices(idx) + 1);
    check({tag, " result"}, res[idx], exp[31:0]);
    check({tag, " carry"}, cout[idx], exp[32]);
    check({tag, " zero"}, zero[idx], exp[31:0] == 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, val_out[idx], 1);
      check({tag, " hold_result"}, res[idx], exp[31:0]);
      check({tag, " hold_ready"}, rdy_out[idx], 0);
    end
    rdy_in[idx] = 1'b1;
    @(negedge clk);
    rdy_in[idx] = 1'b0;
    check({tag, " valid_drop"}, val_out[idx], 0);
    check({tag, " ready_back"}, rdy_out[idx], 1);
    check({tag, " busy_clear"}, busy[idx], 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      vld[i] = 1'b0; opv[i] = 3'd0; av[i] = '0; bv[i] = '0; rdy_in[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst%0d ready", i), rdy_out[i], 1);
      check($sformatf("rst%0d valid", i), val_out[i], 0);
      check($sformatf("rst%0d busy", i), busy[i], 0);
      check($sformatf("rst%0d result", i), res[i], 0);
      check($sformatf("rst%0d carry", i), cout[i], 0);
      check($sformatf("rst%0d zero", i), zero[i], 1);
    end
    rst = 1'b0;

    run_op(0, 3'd0, 32'h0000FFFF, 32'h00000001, 0, "add_slice_carry");
    run_op(0, 3'd0, 32'hFFFFFFFF, 32'h00000001, 1, "add_wrap");
    run_op(0, 3'd1, 32'd5, 32'd7, 0, "sub_5_7");
    run_op(0, 3'd1, 32'd7, 32'd5, 0, "sub_7_5");
    run_op(0, 3'd4, 32'hA5A5A5A5, 32'hFFFF0000, 0, "xor");
    run_op(0, 3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 0, "and");
    run_op(0, 3'd3, 32'h0, 32'h0, 0, "or_zero");
    run_op(0, 3'd4, 32'h12345678, 32'h0F0F0F0F, 10, "backpressure");
    run_op(0, 3'd6, 32'hDEADBEEF, 32'h12345678, 2, "reserved");

    // Reset during the first EXEC cycle discards the operation.
    @(negedge clk);
    vld[0] = 1'b1; opv[0] = 3'd0; av[0] = 32'h12345678; bv[0] = 32'h00000001;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst ready", rdy_out[0], 1);
    check("midrst valid", val_out[0], 0);
    check("midrst result", res[0], 0);
    check("midrst busy", busy[0], 0);
    check("midrst zero", zero[0], 1);
    run_op(0, 3'd0, 32'd2, 32'd3, 0, "add_after_rst");

    run_op(1, 3'd0, 32'h00FF00FF, 32'h00010001, 0, "sw8_add");
    run_op(1, 3'd1, 32'h00000000, 32'h00000001, 3, "sw8_sub");
    run_op(2, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "sw32_add");
    run_op(2, 3'd1, 32'h80000000, 32'h80000000, 1, "sw32_sub");

    for (int n = 0; n < 36; n++) begin
      int          idx;
      logic [2:0]  op;
      logic [31:0] a, b;
      idx = $urandom_range(0, NDUT - 1);
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      if (n % 6 == 0) b = -a;
      if (n % 6 == 1) b = a;
      run_op(idx, op, a, b, $urandom_range(0, 3), $sformatf("rnd%0d_dut%0d_op%0d", n, idx, op));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
